// File: rtl/drive_scheduler_if.sv
// Command and status bundle between the motion controller and drive_scheduler.
interface drive_scheduler_if;
  logic       EN;
  logic [1:0] LineA, LineB;
  logic       OVR_REQ;
  logic [1:0] OvrA, OvrB;
  logic       STOP_REQ;
  logic       FAULT;
  logic [1:0] DriveA, DriveB;
  logic       GrantLine, GrantOvr;
  logic       Halted, FaultLatched;
  logic [7:0] StopCount;

  modport master (
    output EN, LineA, LineB, OVR_REQ, OvrA, OvrB, STOP_REQ, FAULT,
    input  DriveA, DriveB, GrantLine, GrantOvr, Halted, FaultLatched, StopCount
  );
  modport slave (
    input  EN, LineA, LineB, OVR_REQ, OvrA, OvrB, STOP_REQ, FAULT,
    output DriveA, DriveB, GrantLine, GrantOvr, Halted, FaultLatched, StopCount
  );
endinterface

// File: rtl/drive_scheduler.sv
// Drive source arbiter (line / override / stop / fault) with per-motor
// dead-time enforcement on direction reversal.
module drive_scheduler_lane #(
  parameter int DEAD_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  output logic [1:0] drive
);
  localparam int ZW = $clog2(DEAD_CYCLES + 2);
  localparam logic [ZW-1:0] ZMAX = ZW'(DEAD_CYCLES);

  typedef enum logic [1:0] {DIR_NONE, DIR_FWD, DIR_REV} dir_e;

  logic [ZW-1:0] zc;
  dir_e          ld, rdir;
  logic [1:0]    app;

  always_comb begin
    rdir = (req == 2'd0) ? DIR_NONE : (req == 2'd3) ? DIR_REV : DIR_FWD;
    app  = req;
    // reversal is blanked until the motor has seen DEAD_CYCLES of zero drive
    if (rdir != DIR_NONE && ld != DIR_NONE && rdir != ld && zc < ZMAX)
      app = 2'd0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      drive <= 2'd0;
      zc    <= ZMAX;
      ld    <= DIR_NONE;
    end else begin
      drive <= app;
      if (app == 2'd0) begin
        if (zc < ZMAX) zc <= zc + 1'b1;
      end else begin
        zc <= '0;
        ld <= rdir;
      end
    end
  end
endmodule

module drive_scheduler #(
  parameter int DEAD_CYCLES = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic              CLK,
  input  logic              RST,
  drive_scheduler_if.slave  bus
);
  localparam int NUM_LANES = 2;
  localparam int HW = $clog2(HOLD_CYCLES + 2);

  typedef enum logic [2:0] {S_IDLE, S_LINE, S_OVR, S_STOP, S_FAULT} state_e;

  state_e                        state, nstate;
  logic [HW-1:0]                 hold;
  logic [7:0]                    stop_cnt;
  logic [NUM_LANES-1:0][1:0]     line_c, ovr_c, req, drive;
  logic                          gl_d, go_d, halt_d, flt_d;
  logic                          grant_line, grant_ovr, halted, flt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      grant_line <= 1'b0;
      grant_ovr  <= 1'b0;
      halted     <= 1'b0;
      flt        <= 1'b0;
    end else begin
      state      <= nstate;
      grant_line <= gl_d;
      grant_ovr  <= go_d;
      halted     <= halt_d;
      flt        <= flt_d;
    end
  end

  always_comb begin
    nstate = state;
    if (state == S_FAULT || bus.FAULT)  nstate = S_FAULT;
    else if (!bus.EN)                   nstate = S_IDLE;
    else if (bus.STOP_REQ)              nstate = S_STOP;
    else if (state == S_STOP && hold != '0) nstate = S_STOP;
    else                                nstate = bus.OVR_REQ ? S_OVR : S_LINE;
  end

  // Codes follow the current source with one register of latency, but a
  // transition into a halting state zeroes the drives on that same edge.
  always_comb begin
    line_c = {bus.LineB, bus.LineA};
    ovr_c  = {bus.OvrB, bus.OvrA};
    req    = '0;
    if (nstate == S_LINE || nstate == S_OVR) begin
      if (state == S_LINE)     req = line_c;
      else if (state == S_OVR) req = ovr_c;
    end
    gl_d   = (nstate == S_LINE);
    go_d   = (nstate == S_OVR);
    halt_d = (nstate == S_STOP) || (nstate == S_FAULT);
    flt_d  = (nstate == S_FAULT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold     <= '0;
      stop_cnt <= '0;
    end else begin
      if (nstate != S_FAULT) begin
        if (!bus.EN)                            hold <= '0;
        else if (bus.STOP_REQ)                  hold <= HW'(HOLD_CYCLES);
        else if (state == S_STOP && hold != '0) hold <= hold - 1'b1;
      end
      if (nstate == S_STOP && state != S_STOP && stop_cnt != 8'hFF)
        stop_cnt <= stop_cnt + 8'd1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    drive_scheduler_lane #(.DEAD_CYCLES(DEAD_CYCLES)) u_lane (
      .CLK   (CLK),
      .RST   (RST),
      .req   (req[i]),
      .drive (drive[i])
    );
  end

  assign bus.DriveA       = drive[0];
  assign bus.DriveB       = drive[1];
  assign bus.GrantLine    = grant_line;
  assign bus.GrantOvr     = grant_ovr;
  assign bus.Halted       = halted;
  assign bus.FaultLatched = flt;
  assign bus.StopCount    = stop_cnt;
endmodule

// File: tb/tb_drive_scheduler.sv
// Bench for drive_scheduler: hand-computed vector table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_drive_scheduler;
  localparam int D = 4;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  drive_scheduler_if bus();
  drive_scheduler #(.DEAD_CYCLES(D), .HOLD_CYCLES(H)) dut (.CLK(clk), .RST(rst), .bus(bus));

  always #5 clk = ~clk;

  // behavioural model; mode: 0 idle, 1 line, 2 ovr, 3 stop, 4 fault
  int m_mode, m_hold, m_sc;
  int m_zc[2], m_ld[2], m_drv[2];

  function automatic int dirof(input int c);
    return (c == 0) ? 0 : (c == 3) ? 2 : 1;
  endfunction

  task automatic model_step(input bit r, en, input int la, lb, input bit ov,
                            input int oa, ob, input bit st, fl);
    int nm;
    int rq[2];
    int app;
    if (r) begin
      m_mode = 0; m_hold = 0; m_sc = 0;
      for (int i = 0; i < 2; i++) begin m_zc[i] = D; m_ld[i] = 0; m_drv[i] = 0; end
      return;
    end
    if (m_mode == 4 || fl)             nm = 4;
    else if (!en)                      nm = 0;
    else if (st)                       nm = 3;
    else if (m_mode == 3 && m_hold > 0) nm = 3;
    else                               nm = ov ? 2 : 1;
    rq[0] = 0; rq[1] = 0;
    if (nm == 1 || nm == 2) begin
      if (m_mode == 1) begin rq[0] = la; rq[1] = lb; end
      if (m_mode == 2) begin rq[0] = oa; rq[1] = ob; end
    end
    if (nm != 4) begin
      if (!en)                              m_hold = 0;
      else if (st)                          m_hold = H;
      else if (m_mode == 3 && m_hold > 0)   m_hold = m_hold - 1;
    end
    if (nm == 3 && m_mode != 3 && m_sc < 255) m_sc++;
    for (int i = 0; i < 2; i++) begin
      app = rq[i];
      if (dirof(app) != 0 && m_ld[i] != 0 && dirof(app) != m_ld[i] && m_zc[i] < D) app = 0;
      if (app == 0) m_zc[i] = (m_zc[i] < D) ? m_zc[i] + 1 : D;
      else begin m_zc[i] = 0; m_ld[i] = dirof(app); end
      m_drv[i] = app;
    end
    m_mode = nm;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("DriveA",       int'(bus.DriveA),       m_drv[0]);
    chk("DriveB",       int'(bus.DriveB),       m_drv[1]);
    chk("GrantLine",    int'(bus.GrantLine),    int'(m_mode == 1));
    chk("GrantOvr",     int'(bus.GrantOvr),     int'(m_mode == 2));
    chk("Halted",       int'(bus.Halted),       int'(m_mode == 3 || m_mode == 4));
    chk("FaultLatched", int'(bus.FaultLatched), int'(m_mode == 4));
    chk("StopCount",    int'(bus.StopCount),    m_sc);
  endtask

  // one clock: apply inputs, advance model at the edge, compare 1 time unit later
  task automatic cyc(input bit r, en, input int la, lb, input bit ov,
                     input int oa, ob, input bit st, fl);
    rst = r; bus.EN = en; bus.LineA = 2'(la); bus.LineB = 2'(lb);
    bus.OVR_REQ = ov; bus.OvrA = 2'(oa); bus.OvrB = 2'(ob);
    bus.STOP_REQ = st; bus.FAULT = fl;
    @(posedge clk);
    model_step(r, en, la, lb, ov, oa, ob, st, fl);
    #1;
    chk_model();
  endtask

  typedef struct {
    bit r, en; int la, lb; bit ov; int oa, ob; bit st, fl;
    int ea, eb; bit egl, ego, eh, ef; int esc;
  } vec_t;

  function automatic vec_t mk(bit r, en, int la, lb, bit ov, int oa, ob, bit st, fl,
                              int ea, eb, bit egl, ego, eh, ef, int esc);
    vec_t v;
    v.r = r; v.en = en; v.la = la; v.lb = lb; v.ov = ov; v.oa = oa; v.ob = ob;
    v.st = st; v.fl = fl; v.ea = ea; v.eb = eb; v.egl = egl; v.ego = ego;
    v.eh = eh; v.ef = ef; v.esc = esc;
    return v;
  endfunction

  vec_t tbl[23];
  int   sc_snap;

  initial begin
    // reset, line start, reversal dead-time on A only, 3-cycle stop pulse and hold
    tbl[0] = mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    tbl[1] = mk(0,1,1,1,0,0,0,0,0, 0,0,1,0,0,0,0);
    tbl[2] = mk(0,1,1,1,0,0,0,0,0, 1,1,1,0,0,0,0);
    tbl[3] = mk(0,1,1,1,0,0,0,0,0, 1,1,1,0,0,0,0);
    for (int i = 4; i < 8; i++) tbl[i] = mk(0,1,3,1,0,0,0,0,0, 0,1,1,0,0,0,0);
    tbl[8] = mk(0,1,3,1,0,0,0,0,0, 3,1,1,0,0,0,0);
    tbl[9] = mk(0,1,3,2,0,0,0,0,0, 3,2,1,0,0,0,0);
    for (int i = 10; i < 13; i++) tbl[i] = mk(0,1,3,2,0,0,0,1,0, 0,0,0,0,1,0,1);
    for (int i = 13; i < 21; i++) tbl[i] = mk(0,1,3,2,0,0,0,0,0, 0,0,0,0,1,0,1);
    tbl[21] = mk(0,1,3,2,0,0,0,0,0, 0,0,1,0,0,0,1);
    tbl[22] = mk(0,1,3,2,0,0,0,0,0, 3,2,1,0,0,0,1);

    @(negedge clk);
    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].r, tbl[i].en, tbl[i].la, tbl[i].lb, tbl[i].ov, tbl[i].oa, tbl[i].ob,
          tbl[i].st, tbl[i].fl);
      chk($sformatf("vec%0d.DriveA", i),    int'(bus.DriveA),       tbl[i].ea);
      chk($sformatf("vec%0d.DriveB", i),    int'(bus.DriveB),       tbl[i].eb);
      chk($sformatf("vec%0d.GrantLine", i), int'(bus.GrantLine),    int'(tbl[i].egl));
      chk($sformatf("vec%0d.GrantOvr", i),  int'(bus.GrantOvr),     int'(tbl[i].ego));
      chk($sformatf("vec%0d.Halted", i),    int'(bus.Halted),       int'(tbl[i].eh));
      chk($sformatf("vec%0d.Fault", i),     int'(bus.FaultLatched), int'(tbl[i].ef));
      chk($sformatf("vec%0d.StopCount", i), int'(bus.StopCount),    tbl[i].esc);
    end

    // override grant and release
    cyc(0,1,3,2,1,2,2,0,0);
    chk("ovr.GrantOvr", int'(bus.GrantOvr), 1);
    chk("ovr.GrantLine", int'(bus.GrantLine), 0);
    cyc(0,1,3,2,1,2,2,0,0);
    cyc(0,1,3,2,0,2,2,0,0);
    chk("ovr_rel.GrantLine", int'(bus.GrantLine), 1);

    // fault in OVR latches through input churn until reset
    cyc(0,1,1,1,1,2,2,0,0);
    cyc(0,1,1,1,1,2,2,0,1);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1'($urandom), $urandom_range(0,3), $urandom_range(0,3), 1'($urandom),
          $urandom_range(0,3), $urandom_range(0,3), 1'($urandom), 0);
      chk("fault.Latched", int'(bus.FaultLatched), 1);
      chk("fault.Drives", int'({bus.DriveA, bus.DriveB}), 0);
    end
    cyc(1,1,1,1,0,0,0,0,1);
    chk("rst_over_fault", int'(bus.FaultLatched), 0);

    // stop re-asserted at hold count 2
    cyc(0,1,1,1,0,0,0,0,0);
    cyc(0,1,1,1,0,0,0,1,0);
    for (int i = 0; i < 6; i++) cyc(0,1,1,1,0,0,0,0,0);
    cyc(0,1,1,1,0,0,0,1,0);
    chk("restop.StopCount", int'(bus.StopCount), 1);
    for (int i = 0; i < H; i++) begin
      cyc(0,1,1,1,0,0,0,0,0);
      chk("restop.Halted", int'(bus.Halted), 1);
    end
    cyc(0,1,1,1,0,0,0,0,0);
    chk("restop.Resume", int'(bus.GrantLine), 1);

    // simultaneous fault and stop: fault wins, no stop counted
    sc_snap = int'(bus.StopCount);
    cyc(0,1,1,1,0,0,0,1,1);
    chk("fault_stop.Latched", int'(bus.FaultLatched), 1);
    chk("fault_stop.StopCount", int'(bus.StopCount), sc_snap);

    // StopCount saturation
    cyc(1,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 260; i++) begin
      cyc(0,1,0,0,0,0,0,1,0);
      cyc(0,0,0,0,0,0,0,0,0);
    end
    chk("sat.StopCount", int'(bus.StopCount), 255);

    // randomized traffic
    cyc(1,0,0,0,0,0,0,0,0);
    for (int n = 0; n < 3000; n++) begin
      bit r;
      r = (m_mode == 4) ? ($urandom_range(0,19) == 0) : ($urandom_range(0,199) == 0);
      cyc(r, $urandom_range(0,19) != 0, $urandom_range(0,3), $urandom_range(0,3),
          $urandom_range(0,3) == 0, $urandom_range(0,3), $urandom_range(0,3),
          $urandom_range(0,9) == 0, $urandom_range(0,399) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
